// File: rtl/rc_serial_add.sv
// Multi-word adder sequencer: drives one external 4-bit ripple-carry adder per
// clock to add two 4*WORDS-bit operands, least-significant slice first.
module rc_serial_add #(
    parameter int unsigned WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*WORDS-1:0]   a,
    input  logic [4*WORDS-1:0]   b,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*WORDS-1:0]   sum,
    output logic                 cout,
    output logic                 ovf,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_c,
    input  logic [3:0]           add_s,
    input  logic                 add_co
);

    localparam int unsigned W     = 4 * WORDS;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [W-1:0]     sum_reg;
    logic             carry;
    logic             ovf_reg;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             last;

    assign accept = in_valid && (state == IDLE);
    assign last   = (idx == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Operand capture and per-slice accumulation; the top slice's sum bit is
    // taken straight from the adder so ovf lands together with DONE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
            carry   <= 1'b0;
            ovf_reg <= 1'b0;
            idx     <= '0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            idx   <= '0;
        end else if (state == RUN) begin
            sum_reg[4*idx +: 4] <= add_s;
            carry               <= add_co;
            if (last) begin
                ovf_reg <= (a_reg[W-1] == b_reg[W-1]) && (add_s[3] != a_reg[W-1]);
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    // Adder slice drive, quiet outside RUN
    always_comb begin
        add_a = 4'h0;
        add_b = 4'h0;
        add_c = 1'b0;
        if (state == RUN) begin
            add_a = a_reg[4*idx +: 4];
            add_b = b_reg[4*idx +: 4];
            add_c = carry;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_reg;
    assign cout      = carry;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_rc_serial_add.sv
// Self-checking bench for rc_serial_add (WORDS = 4) with a behavioural 4-bit
// adder and a whole-operand arithmetic reference.
module tb_rc_serial_add;

    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_c;
    logic [3:0]   add_s;
    logic         add_co;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // External combinational 4-bit adder
    assign {add_co, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_c);

    rc_serial_add #(.WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf),
        .add_a(add_a), .add_b(add_b), .add_c(add_c),
        .add_s(add_s), .add_co(add_co)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic c);
        logic [16:0] t;
        logic        ov;
        t  = 17'(x) + 17'(y) + 17'(c);
        ov = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return {ov, t};
    endfunction

    // Carry entering slice i of the full-width addition
    function automatic logic carry_into(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic c, input int i);
        logic [16:0] mask;
        logic [16:0] t;
        mask = (17'(1) << (4 * i)) - 17'(1);
        t    = (17'(x) & mask) + (17'(y) & mask) + 17'(c);
        return t[4*i];
    endfunction

    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
        logic [17:0]  r;
        logic [W-1:0] sa;
        logic [W-1:0] sb;
        int           n;
        r = ref_add(xa, xb, xc);
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = xa;
        b = xb;
        cin = xc;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sa = xa >> (4 * i);
            sb = xb >> (4 * i);
            chk("slice_a", 32'(add_a), 32'(sa[3:0]));
            chk("slice_b", 32'(add_b), 32'(sb[3:0]));
            chk("slice_c", 32'(add_c), 32'(carry_into(xa, xb, xc, i)));
            chk("run_no_valid", 32'(out_valid), 32'd0);
            tick();
        end
        chk("latency_valid", 32'(out_valid), 32'd1);
        chk("sum", 32'(sum), 32'(r[15:0]));
        chk("cout", 32'(cout), 32'(r[16]));
        chk("ovf", 32'(ovf), 32'(r[17]));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_hs_valid", 32'(out_valid), 32'd0);
        chk("post_hs_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [17:0]  r;
        logic [W-1:0] ba [3];
        logic [W-1:0] bb [3];
        logic         bc [3];
        int           acc_cyc [3];
        int           nxt;
        int           nres;
        int           cyc;
        logic         fire_in;
        logic         fire_out;

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_add_a", 32'(add_a), 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed arithmetic cases
        run_op(16'h0001, 16'h0001, 1'b0);
        chk("idle_add_a", 32'(add_a), 32'd0);
        chk("held_sum", 32'(sum), 32'h0002);
        run_op(16'hFFFF, 16'h0001, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0);
        run_op(16'h00FF, 16'hFF00, 1'b1);

        // Backpressure with competing operands offered during DONE
        in_valid = 1'b1;
        a = 16'h1111;
        b = 16'h2222;
        cin = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("bp_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        a = 16'hAAAA;
        b = 16'h5555;
        cin = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_sum", 32'(sum), 32'h3333);
            chk("bp_cout", 32'(cout), 32'd0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_add_a", 32'(add_a), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_hs_ready", 32'(in_ready), 32'd1);
        chk("bp_hs_valid", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        chk("bp_accepted", 32'(in_ready), 32'd0);
        chk("bp_slice0", 32'(add_a), 32'hA);
        repeat (4) tick();
        r = ref_add(16'hAAAA, 16'h5555, 1'b1);
        chk("bp_new_valid", 32'(out_valid), 32'd1);
        chk("bp_new_sum", 32'(sum), 32'(r[15:0]));
        chk("bp_new_cout", 32'(cout), 32'(r[16]));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Asynchronous reset in the middle of RUN
        in_valid = 1'b1;
        a = 16'hFFFF;
        b = 16'h0001;
        cin = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_sum", 32'(sum), 32'd0);
        chk("arst_cout", 32'(cout), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        chk("arst_add", 32'({add_a, add_b, add_c}), 32'd0);
        tick();
        tick();
        chk("arst_hold_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("arst_release_idle", 32'(in_ready), 32'd1);
        run_op(16'h1234, 16'h4321, 1'b0);

        // Back-to-back issue with both handshakes tied high
        for (int i = 0; i < 3; i++) begin
            ba[i] = W'($urandom);
            bb[i] = W'($urandom);
            bc[i] = 1'($urandom);
            acc_cyc[i] = 0;
        end
        nxt = 0;
        nres = 0;
        cyc = 0;
        in_valid = 1'b1;
        a = ba[0];
        b = bb[0];
        cin = bc[0];
        out_ready = 1'b1;
        while (nres < 3 && cyc < 60) begin
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                r = ref_add(ba[nres], bb[nres], bc[nres]);
                chk("b2b_sum", 32'(sum), 32'(r[15:0]));
                chk("b2b_cout", 32'(cout), 32'(r[16]));
                chk("b2b_ovf", 32'(ovf), 32'(r[17]));
                nres++;
            end
            tick();
            cyc++;
            if (fire_in) begin
                acc_cyc[nxt] = cyc;
                nxt++;
                if (nxt < 3) begin
                    a = ba[nxt];
                    b = bb[nxt];
                    cin = bc[nxt];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        chk("b2b_results", 32'(nres), 32'd3);
        chk("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
        chk("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);
        tick();

        // Random operands
        for (int i = 0; i < 10; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
